// File: rtl/mlp_forward_seq.sv
// rtl/mlp_forward_seq.sv - sequential 16-N-1 MLP forward pass, one MAC per cycle
// Produces ReLU hidden activations, saturated score, class and training error.
module mlp_forward_seq #(
  parameter int W    = 8,
  parameter int N    = 8,
  parameter int FRAC = 6
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       start,
  input  logic [15:0]                x,
  input  logic signed [W-1:0]        target,
  input  logic signed [N*16*W-1:0]   w_h_bus,
  input  logic signed [N*W-1:0]      b_h_bus,
  input  logic signed [N*W-1:0]      w_o_bus,
  input  logic signed [W-1:0]        b_o_in,
  output logic                       busy,
  output logic                       done,
  output logic signed [N*(W+5)-1:0]  h_act_bus,
  output logic signed [W-1:0]        y_out,
  output logic                       pred,
  output logic signed [W-1:0]        err
);

  localparam int HW    = W + 5;
  localparam int ACC_W = 2 * W + 8;
  localparam int IW    = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, HID, OUT, FIN} state_t;

  state_t                    state_q;
  logic [IW-1:0]             i_q;
  logic [3:0]                j_q;
  logic signed [HW-1:0]      hacc_q;
  logic signed [ACC_W-1:0]   yacc_q;
  logic [15:0]               x_q;
  logic signed [W-1:0]       target_q;
  logic signed [HW-1:0]      h_q [N];
  logic                      busy_q;
  logic                      done_q;
  logic signed [N*HW-1:0]    h_act_q;
  logic signed [W-1:0]       y_q;
  logic                      pred_q;
  logic signed [W-1:0]       err_q;

  logic [IW-1:0]             i_nxt;
  logic                      i_last;
  logic signed [W-1:0]       w_h_sel;
  logic signed [W-1:0]       b_h_nxt;
  logic signed [W-1:0]       w_o_sel;
  logic signed [HW-1:0]      w_h_ext;
  logic signed [HW-1:0]      hacc_d;
  logic signed [HW-1:0]      relu_d;
  logic signed [ACC_W-1:0]   w_o_ext;
  logic signed [ACC_W-1:0]   h_ext;
  logic signed [ACC_W-1:0]   prod;
  logic signed [ACC_W-1:0]   yacc_d;
  logic signed [ACC_W-1:0]   yacc_load;
  logic signed [ACC_W-1:0]   y_shift;
  logic                      y_ovf;
  logic signed [W-1:0]       y_sat;
  logic signed [W:0]         diff;
  logic signed [W-1:0]       err_sat;

  always_comb begin
    i_last  = (i_q == IW'(N - 1));
    i_nxt   = i_last ? '0 : i_q + IW'(1);
    w_h_sel = w_h_bus[(int'(i_q) * 16 + int'(j_q)) * W +: W];
    b_h_nxt = b_h_bus[int'(i_nxt) * W +: W];
    w_o_sel = w_o_bus[int'(i_q) * W +: W];

    // Input bit 0 encodes -1, so the weight is subtracted instead of added.
    w_h_ext = {{(HW - W){w_h_sel[W-1]}}, w_h_sel};
    hacc_d  = x_q[j_q] ? hacc_q + w_h_ext : hacc_q - w_h_ext;
    relu_d  = hacc_d[HW-1] ? '0 : hacc_d;

    w_o_ext = {{(ACC_W - W){w_o_sel[W-1]}}, w_o_sel};
    h_ext   = {{(ACC_W - HW){h_q[i_q][HW-1]}}, h_q[i_q]};
    prod    = w_o_ext * h_ext;
    yacc_d  = yacc_q + prod;

    yacc_load = {{(ACC_W - W){b_o_in[W-1]}}, b_o_in} << FRAC;

    y_shift = yacc_q >>> FRAC;
    y_ovf   = !((&y_shift[ACC_W-1:W-1]) || (~|y_shift[ACC_W-1:W-1]));
    y_sat   = y_ovf ? (y_shift[ACC_W-1] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                    : y_shift[W-1:0];

    diff    = {target_q[W-1], target_q} - {y_sat[W-1], y_sat};
    err_sat = (diff[W] != diff[W-1]) ? (diff[W] ? {1'b1, {(W-1){1'b0}}} : {1'b0, {(W-1){1'b1}}})
                                     : diff[W-1:0];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      i_q      <= '0;
      j_q      <= '0;
      hacc_q   <= '0;
      yacc_q   <= '0;
      x_q      <= '0;
      target_q <= '0;
      for (int k = 0; k < N; k++) h_q[k] <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      h_act_q  <= '0;
      y_q      <= '0;
      pred_q   <= 1'b0;
      err_q    <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            x_q      <= x;
            target_q <= target;
            i_q      <= '0;
            j_q      <= '0;
            hacc_q   <= {{(HW - W){b_h_bus[W-1]}}, b_h_bus[W-1:0]};
            yacc_q   <= yacc_load;
            busy_q   <= 1'b1;
            state_q  <= HID;
          end
        end
        HID: begin
          j_q <= j_q + 4'd1;
          if (j_q == 4'd15) begin
            h_q[i_q] <= relu_d;
            hacc_q   <= {{(HW - W){b_h_nxt[W-1]}}, b_h_nxt};
            i_q      <= i_nxt;
            if (i_last) state_q <= OUT;
          end else begin
            hacc_q <= hacc_d;
          end
        end
        OUT: begin
          yacc_q <= yacc_d;
          i_q    <= i_nxt;
          if (i_last) state_q <= FIN;
        end
        FIN: begin
          y_q    <= y_sat;
          pred_q <= ~y_sat[W-1];
          err_q  <= err_sat;
          for (int k = 0; k < N; k++) h_act_q[k*HW +: HW] <= h_q[k];
          done_q  <= 1'b1;
          busy_q  <= 1'b0;
          state_q <= IDLE;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign h_act_bus = h_act_q;
  assign y_out     = y_q;
  assign pred      = pred_q;
  assign err       = err_q;

endmodule

// File: tb/tb_mlp_forward_seq.sv
// tb/tb_mlp_forward_seq.sv - directed-vector bench for mlp_forward_seq
module tb_mlp_forward_seq;

  localparam int W  = 8;
  localparam int N  = 8;
  localparam int HW = W + 5;
  localparam int LAT = 17 * N + 1;

  logic                      clk = 1'b0;
  logic                      rst_n;
  logic                      start;
  logic [15:0]               x;
  logic signed [W-1:0]       target;
  logic signed [N*16*W-1:0]  w_h_bus;
  logic signed [N*W-1:0]     b_h_bus;
  logic signed [N*W-1:0]     w_o_bus;
  logic signed [W-1:0]       b_o_in;
  logic                      busy;
  logic                      done;
  logic signed [N*HW-1:0]    h_act_bus;
  logic signed [W-1:0]       y_out;
  logic                      pred;
  logic signed [W-1:0]       err;

  int n_checks = 0;
  int n_errors = 0;

  mlp_forward_seq #(.W(W), .N(N), .FRAC(6)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .x(x), .target(target),
    .w_h_bus(w_h_bus), .b_h_bus(b_h_bus), .w_o_bus(w_o_bus), .b_o_in(b_o_in),
    .busy(busy), .done(done), .h_act_bus(h_act_bus), .y_out(y_out),
    .pred(pred), .err(err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic set_all(input int wh, input int bh, input int wo, input int bo);
    for (int k = 0; k < N * 16; k++) w_h_bus[k*W +: W] = W'(wh);
    for (int k = 0; k < N; k++) begin
      b_h_bus[k*W +: W] = W'(bh);
      w_o_bus[k*W +: W] = W'(wo);
    end
    b_o_in = W'(bo);
  endtask

  task automatic check_outputs(input string tag, input int eh, input int ey,
                               input int ep, input int ee);
    logic signed [HW-1:0] hv;
    for (int k = 0; k < N; k++) begin
      hv = h_act_bus[k*HW +: HW];
      check($sformatf("%s:h%0d", tag, k), int'(hv), eh);
    end
    check({tag, ":y_out"}, int'(y_out), ey);
    check({tag, ":pred"}, int'(pred), ep);
    check({tag, ":err"}, int'(err), ee);
  endtask

  // poke: disturb x/target and pulse start while the run is in progress.
  task automatic run(input string tag, input int eh, input int ey, input int ep,
                     input int ee, input bit poke);
    int cnt;
    int ndone;
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    check({tag, ":busy"}, int'(busy), 1);
    cnt = 0;
    while (!done && cnt < 400) begin
      @(posedge clk); #1;
      cnt++;
      if (poke && cnt == 30) begin x = ~x; target = 8'sd100; end
      if (poke && cnt == 40) start = 1'b1;
      if (poke && cnt == 41) start = 1'b0;
    end
    check({tag, ":latency"}, cnt, LAT);
    check({tag, ":busy_at_done"}, int'(busy), 0);
    check_outputs(tag, eh, ey, ep, ee);
    if (poke) begin
      ndone = 0;
      repeat (160) begin
        @(posedge clk); #1;
        if (done) ndone++;
      end
      check({tag, ":extra_done"}, ndone, 0);
    end
  endtask

  task automatic wait_done(output int cnt);
    cnt = 0;
    do begin
      @(posedge clk); #1;
      cnt++;
    end while (!done && cnt < 400);
  endtask

  initial begin
    int cnt;
    int ndone;
    rst_n = 1'b0;
    start = 1'b0;
    x = 16'h0000;
    target = '0;
    set_all(0, 0, 0, 0);
    repeat (3) @(posedge clk);
    #1;
    check("rst:busy", int'(busy), 0);
    check("rst:done", int'(done), 0);
    check("rst:h_zero", int'(h_act_bus == '0), 1);
    check("rst:y_out", int'(y_out), 0);
    check("rst:pred", int'(pred), 0);
    check("rst:err", int'(err), 0);
    rst_n = 1'b1;

    x = 16'hA5A5; target = 8'sd20; set_all(0, 0, 0, 5);
    run("bias_only", 0, 5, 1, 15, 1'b0);

    x = 16'hFFFF; target = 8'sd0; set_all(1, 0, 1, 0);
    run("ones", 16, 2, 1, -2, 1'b1);

    x = 16'h0000; target = 8'sd0; set_all(1, 0, 1, 0);
    run("relu_zero", 0, 0, 1, 0, 1'b0);

    set_all(1, 0, 1, -3);
    run("neg_bias", 0, -3, 0, 3, 1'b0);

    x = 16'h00FF; target = 8'sd10; set_all(1, 3, -20, 1);
    run("floor_shift", 3, -7, 0, 17, 1'b0);

    x = 16'hFFFF; target = -8'sd128; set_all(127, 127, 127, 127);
    run("saturate", 2159, 127, 1, -128, 1'b0);

    // start held high: second run accepted in the done cycle of the first.
    x = 16'hFFFF; target = 8'sd0; set_all(1, 0, 1, 0);
    @(negedge clk);
    start = 1'b1;
    wait_done(cnt);
    check("b2b:first_latency", cnt, LAT + 1);
    wait_done(cnt);
    start = 1'b0;
    check("b2b:period", cnt, LAT + 1);
    check_outputs("b2b", 16, 2, 1, -2);
    ndone = 0;
    repeat (150) begin
      @(posedge clk); #1;
      if (done) ndone++;
    end
    check("b2b:no_third_run", ndone, 0);

    // Abort a run with reset at cycle 50; prior outputs are nonzero.
    @(negedge clk);
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (50) @(posedge clk);
    #1;
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort:busy", int'(busy), 0);
    check("abort:done", int'(done), 0);
    check("abort:h_zero", int'(h_act_bus == '0), 1);
    check("abort:y_out", int'(y_out), 0);
    check("abort:pred", int'(pred), 0);
    check("abort:err", int'(err), 0);
    rst_n = 1'b1;
    x = 16'h1234; target = 8'sd20; set_all(0, 0, 0, 5);
    run("after_abort", 0, 5, 1, 15, 1'b0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
